// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry instruction queue between fetch and decode, with a registered
// {pc, inst} output, bypass when empty, branch flush and stale-fetch suppression.
`default_nettype none

module if_id_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 2,
  parameter int PC_W    = 32,
  parameter int INST_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_valid_i,
  input  logic [PC_W-1:0]     if_pc_i,
  input  logic [INST_W-1:0]   if_inst_i,
  output logic                if_ready_o,
  input  logic [STALL_W-1:0]  stall,
  input  logic                id_b_flag_i,
  input  logic                ex_b_flag_i,
  output logic [PC_W-1:0]     id_pc_o,
  output logic [INST_W-1:0]   id_inst_o,
  output logic                id_valid_o,
  output logic [ADDR_W:0]     count_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              drop_pending;

  logic flush;
  logic push_try;
  logic push_ok;
  logic advance;
  logic empty;
  logic pop;
  logic bypass;
  logic store;
  logic unused_stall;

  assign unused_stall = ^{stall[STALL_W-1:3], stall[0]};

  assign flush      = id_b_flag_i | ex_b_flag_i;
  assign if_ready_o = (count != FULL_CNT);
  assign push_try   = if_valid_i & if_ready_o & ~stall[1];
  // A push that arrives while the stale fetch is still owed is swallowed here.
  assign push_ok    = push_try & ~drop_pending & ~flush;
  assign advance    = ~stall[2];
  assign empty      = (count == '0);
  assign pop        = advance & ~empty & ~flush;
  assign bypass     = advance & empty & push_ok;
  assign store      = push_ok & ~bypass;
  assign count_o    = count;

  always_comb begin
    count_nxt = count;
    if (store && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !store)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (store) begin
      pc_mem[wr_ptr]   <= if_pc_i;
      inst_mem[wr_ptr] <= if_inst_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      drop_pending <= 1'b0;
      id_pc_o      <= '0;
      id_inst_o    <= '0;
      id_valid_o   <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      drop_pending <= stall[1];
      id_pc_o      <= '0;
      id_inst_o    <= '0;
      id_valid_o   <= 1'b0;
    end else begin
      if (push_try && drop_pending)
        drop_pending <= 1'b0;
      if (store)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      if (advance) begin
        if (pop) begin
          id_pc_o    <= pc_mem[rd_ptr];
          id_inst_o  <= inst_mem[rd_ptr];
          id_valid_o <= 1'b1;
        end else if (bypass) begin
          id_pc_o    <= if_pc_i;
          id_inst_o  <= if_inst_i;
          id_valid_o <= 1'b1;
        end else begin
          id_pc_o    <= '0;
          id_inst_o  <= '0;
          id_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, corner sequences, then random traffic
// compared against a queue-based reference model.
`default_nettype none

module tb_if_id_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int STALL_W = 6;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               if_valid_i;
  logic [PC_W-1:0]    if_pc_i;
  logic [INST_W-1:0]  if_inst_i;
  logic               if_ready_o;
  logic [STALL_W-1:0] stall;
  logic               id_b_flag_i;
  logic               ex_b_flag_i;
  logic [PC_W-1:0]    id_pc_o;
  logic [INST_W-1:0]  id_inst_o;
  logic               id_valid_o;
  logic [ADDR_W:0]    count_o;

  if_id_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PC_W(PC_W), .INST_W(INST_W), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .if_ready_o(if_ready_o), .stall(stall),
    .id_b_flag_i(id_b_flag_i), .ex_b_flag_i(ex_b_flag_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a plain FIFO of {pc, inst} plus the visible output register.
  logic [63:0] mq[$];
  logic [31:0] m_pc, m_inst;
  logic        m_valid, m_drop;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [5:0]  st;
    logic        ev;
    logic [31:0] epc;
    int          ecnt;
    logic        erdy;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 0; m_inst = 0; m_valid = 0; m_drop = 0;
  endtask

  task automatic model_step(logic v, logic [31:0] pc, logic [31:0] inst,
                            logic [5:0] st, logic fl);
    bit rdy, acc, keep;
    rdy = (mq.size() < DEPTH);
    if (fl) begin
      mq.delete();
      m_pc = 0; m_inst = 0; m_valid = 0;
      m_drop = st[1];
    end else begin
      acc  = v && rdy && !st[1];
      keep = acc && !m_drop;
      if (acc && m_drop) m_drop = 0;
      if (!st[2]) begin
        if (mq.size() > 0) begin
          {m_pc, m_inst} = mq.pop_front();
          m_valid = 1;
          if (keep) mq.push_back({pc, inst});
        end else if (keep) begin
          m_pc = pc; m_inst = inst; m_valid = 1;
        end else begin
          m_pc = 0; m_inst = 0; m_valid = 0;
        end
      end else if (keep) begin
        mq.push_back({pc, inst});
      end
    end
  endtask

  task automatic step(logic v, logic [31:0] pc, logic [5:0] st, logic idb, logic exb);
    if_valid_i  = v;
    if_pc_i     = pc;
    if_inst_i   = inst_of(pc);
    stall       = st;
    id_b_flag_i = idb;
    ex_b_flag_i = exb;
    model_step(v, pc, inst_of(pc), st, idb | exb);
    @(posedge clk);
    #1;
    chk("model_valid", 64'(id_valid_o), 64'(m_valid));
    chk("model_pc",    64'(id_pc_o),    64'(m_pc));
    chk("model_inst",  64'(id_inst_o),  64'(m_inst));
    chk("model_count", 64'(count_o),    64'(mq.size()));
    chk("model_ready", 64'(if_ready_o), 64'(mq.size() < DEPTH));
  endtask

  initial begin
    rst_n = 0; if_valid_i = 0; if_pc_i = 0; if_inst_i = 0;
    stall = 0; id_b_flag_i = 0; ex_b_flag_i = 0;
    model_reset();

    // Bypass through an empty queue, then fill under an ID stall and drain.
    vecs[0]  = '{1, 32'h00, 6'h00, 1, 32'h00, 0, 1};
    vecs[1]  = '{1, 32'h04, 6'h00, 1, 32'h04, 0, 1};
    vecs[2]  = '{1, 32'h08, 6'h00, 1, 32'h08, 0, 1};
    vecs[3]  = '{1, 32'h0C, 6'h00, 1, 32'h0C, 0, 1};
    vecs[4]  = '{1, 32'h10, 6'h04, 1, 32'h0C, 1, 1};
    vecs[5]  = '{1, 32'h14, 6'h04, 1, 32'h0C, 2, 1};
    vecs[6]  = '{1, 32'h18, 6'h04, 1, 32'h0C, 3, 1};
    vecs[7]  = '{1, 32'h1C, 6'h04, 1, 32'h0C, 4, 0};
    vecs[8]  = '{1, 32'h20, 6'h04, 1, 32'h0C, 4, 0};
    vecs[9]  = '{1, 32'h20, 6'h04, 1, 32'h0C, 4, 0};
    vecs[10] = '{0, 32'h00, 6'h00, 1, 32'h10, 3, 1};
    vecs[11] = '{0, 32'h00, 6'h00, 1, 32'h14, 2, 1};
    vecs[12] = '{0, 32'h00, 6'h00, 1, 32'h18, 1, 1};
    vecs[13] = '{0, 32'h00, 6'h00, 1, 32'h1C, 0, 1};
    vecs[14] = '{0, 32'h00, 6'h00, 0, 32'h00, 0, 1};

    #23;
    chk("reset_valid", 64'(id_valid_o), 0);
    chk("reset_pc",    64'(id_pc_o),    0);
    chk("reset_inst",  64'(id_inst_o),  0);
    chk("reset_count", 64'(count_o),    0);
    chk("reset_ready", 64'(if_ready_o), 1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].v, vecs[i].pc, vecs[i].st, 0, 0);
      chk($sformatf("vec%0d_valid", i), 64'(id_valid_o), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_pc", i),    64'(id_pc_o),    64'(vecs[i].epc));
      chk($sformatf("vec%0d_count", i), 64'(count_o),    64'(vecs[i].ecnt));
      chk($sformatf("vec%0d_ready", i), 64'(if_ready_o), 64'(vecs[i].erdy));
    end

    // EX flush with a simultaneous push on a 3-entry queue.
    step(1, 32'h24, 6'h04, 0, 0);
    step(1, 32'h28, 6'h04, 0, 0);
    step(1, 32'h2C, 6'h04, 0, 0);
    chk("pre_flush_count", 64'(count_o), 3);
    step(1, 32'h30, 6'h00, 0, 1);
    chk("flush_count", 64'(count_o),    0);
    chk("flush_inst",  64'(id_inst_o),  0);
    chk("flush_valid", 64'(id_valid_o), 0);
    step(0, 32'h00, 6'h00, 0, 0);
    chk("flush_no_ghost", 64'(id_valid_o), 0);

    // ID flush while IF is stalled: the next accepted fetch is stale.
    step(1, 32'h3C, 6'h02, 1, 0);
    chk("drop_flush_valid", 64'(id_valid_o), 0);
    step(1, 32'h40, 6'h00, 0, 0);
    chk("drop_discard_valid", 64'(id_valid_o), 0);
    chk("drop_discard_count", 64'(count_o),    0);
    step(1, 32'h44, 6'h00, 0, 0);
    chk("drop_next_valid", 64'(id_valid_o), 1);
    chk("drop_next_pc",    64'(id_pc_o),    32'h44);
    step(0, 32'h00, 6'h00, 0, 0);

    // Asynchronous reset between edges with two entries held.
    step(1, 32'h50, 6'h04, 0, 0);
    step(1, 32'h54, 6'h04, 0, 0);
    chk("pre_reset_count", 64'(count_o), 2);
    #3;
    rst_n = 0;
    #1;
    chk("async_valid", 64'(id_valid_o), 0);
    chk("async_pc",    64'(id_pc_o),    0);
    chk("async_inst",  64'(id_inst_o),  0);
    chk("async_count", 64'(count_o),    0);
    chk("async_ready", 64'(if_ready_o), 1);
    #2;
    rst_n = 1;
    model_reset();

    // Random traffic; the first stretch has no flushes so pointers wrap several times.
    for (int i = 0; i < 500; i++) begin
      logic       v, idb, exb;
      logic [5:0] st;
      v   = ($urandom % 4) != 0;
      st  = 6'($urandom) & 6'b111001;
      st[1] = ($urandom % 4) == 0;
      st[2] = ($urandom % 3) == 0;
      idb = (i >= 80) && (($urandom % 20) == 0);
      exb = (i >= 80) && (($urandom % 25) == 0);
      step(v, $urandom, st, idb, exb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
